// File: rtl/matmul_fetch_ctrl.sv
// Operand fetch sequencer for the systolic matmul: issues MAT_MUL_SIZE strided
// reads to the A and B BRAMs and times the whole operation for data setup.
module matmul_fetch_ctrl #(
  parameter int MAT_MUL_SIZE       = 8,
  parameter int AWIDTH             = 10,
  parameter int MEM_ACCESS_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [AWIDTH-1:0] address_mat_a,
  input  logic [AWIDTH-1:0] address_mat_b,
  input  logic [AWIDTH-1:0] address_stride_a,
  input  logic [AWIDTH-1:0] address_stride_b,
  output logic [AWIDTH-1:0] a_addr,
  output logic [AWIDTH-1:0] b_addr,
  output logic              a_en,
  output logic              b_en,
  output logic              matmul_op_in_progress,
  output logic [7:0]        clk_cnt,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Last FETCH cycle: fetch window plus the systolic fill/drain and BRAM latency.
  localparam logic [7:0] TERM_C = 8'(3 * MAT_MUL_SIZE + MEM_ACCESS_LATENCY - 1);
  localparam logic [7:0] SIZE_C = 8'(MAT_MUL_SIZE);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [AWIDTH-1:0] stride_a_r;
  logic [AWIDTH-1:0] stride_b_r;
  logic [AWIDTH-1:0] stride_a_nxt_s;
  logic [AWIDTH-1:0] stride_b_nxt_s;
  logic [AWIDTH-1:0] a_addr_nxt_s;
  logic [AWIDTH-1:0] b_addr_nxt_s;
  logic              a_en_nxt_s;
  logic              b_en_nxt_s;
  logic              busy_nxt_s;
  logic              done_nxt_s;
  logic [7:0]        cnt_nxt_s;
  logic [7:0]        cnt_inc_s;

  // Next-state and next-output logic; every output falls back to zero.
  always_comb begin
    state_nxt_s    = state_r;
    stride_a_nxt_s = stride_a_r;
    stride_b_nxt_s = stride_b_r;
    a_addr_nxt_s   = '0;
    b_addr_nxt_s   = '0;
    a_en_nxt_s     = 1'b0;
    b_en_nxt_s     = 1'b0;
    busy_nxt_s     = 1'b0;
    done_nxt_s     = 1'b0;
    cnt_nxt_s      = 8'd0;
    cnt_inc_s      = clk_cnt + 8'd1;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s    = FETCH;
          stride_a_nxt_s = address_stride_a;
          stride_b_nxt_s = address_stride_b;
          a_addr_nxt_s   = address_mat_a;
          b_addr_nxt_s   = address_mat_b;
          a_en_nxt_s     = 1'b1;
          b_en_nxt_s     = 1'b1;
          busy_nxt_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (clk_cnt == TERM_C) begin
          state_nxt_s = DONE;
          done_nxt_s  = 1'b1;
        end else begin
          busy_nxt_s = 1'b1;
          cnt_nxt_s  = cnt_inc_s;
          // Bases are folded into the running address, so only strides are kept.
          if (cnt_inc_s < SIZE_C) begin
            a_addr_nxt_s = a_addr + stride_a_r;
            b_addr_nxt_s = b_addr + stride_b_r;
            a_en_nxt_s   = 1'b1;
            b_en_nxt_s   = 1'b1;
          end else begin
            a_addr_nxt_s = a_addr;
            b_addr_nxt_s = b_addr;
          end
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, latched strides and all outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r               <= IDLE;
      stride_a_r            <= '0;
      stride_b_r            <= '0;
      a_addr                <= '0;
      b_addr                <= '0;
      a_en                  <= 1'b0;
      b_en                  <= 1'b0;
      matmul_op_in_progress <= 1'b0;
      clk_cnt               <= 8'd0;
      done                  <= 1'b0;
    end else begin
      state_r               <= state_nxt_s;
      stride_a_r            <= stride_a_nxt_s;
      stride_b_r            <= stride_b_nxt_s;
      a_addr                <= a_addr_nxt_s;
      b_addr                <= b_addr_nxt_s;
      a_en                  <= a_en_nxt_s;
      b_en                  <= b_en_nxt_s;
      matmul_op_in_progress <= busy_nxt_s;
      clk_cnt               <= cnt_nxt_s;
      done                  <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_matmul_fetch_ctrl.sv
// Self-checking bench for matmul_fetch_ctrl: directed scenarios plus random
// operations, all compared against a cycle-offset arithmetic model.
module tb_matmul_fetch_ctrl;

  localparam int N    = 8;
  localparam int AW   = 10;
  localparam int LAT  = 1;
  localparam int TERM = 3 * N + LAT - 1;

  typedef struct packed {
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          a_en;
    logic          b_en;
    logic          inp;
    logic [7:0]    cnt;
    logic          done;
  } obs_t;

  logic          clk;
  logic          resetn;
  logic          start;
  logic          abort;
  logic [AW-1:0] address_mat_a;
  logic [AW-1:0] address_mat_b;
  logic [AW-1:0] address_stride_a;
  logic [AW-1:0] address_stride_b;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic          a_en;
  logic          b_en;
  logic          matmul_op_in_progress;
  logic [7:0]    clk_cnt;
  logic          done;
  obs_t          obs;

  int checks = 0;
  int errors = 0;

  matmul_fetch_ctrl #(
    .MAT_MUL_SIZE(N),
    .AWIDTH(AW),
    .MEM_ACCESS_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .abort(abort),
    .address_mat_a(address_mat_a),
    .address_mat_b(address_mat_b),
    .address_stride_a(address_stride_a),
    .address_stride_b(address_stride_b),
    .a_addr(a_addr),
    .b_addr(b_addr),
    .a_en(a_en),
    .b_en(b_en),
    .matmul_op_in_progress(matmul_op_in_progress),
    .clk_cnt(clk_cnt),
    .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    obs.a_addr = a_addr;
    obs.b_addr = b_addr;
    obs.a_en   = a_en;
    obs.b_en   = b_en;
    obs.inp    = matmul_op_in_progress;
    obs.cnt    = clk_cnt;
    obs.done   = done;
  end

  // Expected outputs t cycles after acceptance (t<0 or beyond: idle).
  function automatic obs_t model(input int t, input logic [AW-1:0] ba, input logic [AW-1:0] sa,
                                 input logic [AW-1:0] bb, input logic [AW-1:0] sb);
    obs_t e;
    int   k;
    e = '0;
    if (t >= 0 && t <= TERM) begin
      k        = (t < N) ? t : N - 1;
      e.a_addr = AW'(int'(ba) + k * int'(sa));
      e.b_addr = AW'(int'(bb) + k * int'(sb));
      e.a_en   = (t < N);
      e.b_en   = (t < N);
      e.inp    = 1'b1;
      e.cnt    = 8'(t);
    end else if (t == TERM + 1) begin
      e.done = 1'b1;
    end else begin
      e = '0;
    end
    return e;
  endfunction

  // Addresses are not defined during the done cycle.
  function automatic obs_t care(input int t);
    obs_t m;
    m = '1;
    if (t == TERM + 1) begin
      m.a_addr = '0;
      m.b_addr = '0;
    end else begin
      m = '1;
    end
    return m;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("a=%h b=%h ae=%b be=%b inp=%b cnt=%0d done=%b",
                     o.a_addr, o.b_addr, o.a_en, o.b_en, o.inp, o.cnt, o.done);
  endfunction

  // Drive one start request; returns at the first sample point of the op.
  task automatic launch(input logic [AW-1:0] ba, input logic [AW-1:0] sa,
                        input logic [AW-1:0] bb, input logic [AW-1:0] sb, input logic with_abort);
    address_mat_a    = ba;
    address_stride_a = sa;
    address_mat_b    = bb;
    address_stride_b = sb;
    start            = 1'b1;
    abort            = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    obs_t e;
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    address_mat_a = '0;
    address_mat_b = '0;
    address_stride_a = '0;
    address_stride_b = '0;
    #3;
    e = '0;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_async got %s expected %s", fmt(obs), fmt(e));
    end
    @(negedge clk);
    resetn = 1'b1;
    abort  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL idle_abort_ignored i=%0d got %s expected %s", i, fmt(obs), fmt(e));
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_nominal;
    obs_t e;
    int   inp_cycles;
    int   done_pulses;
    inp_cycles  = 0;
    done_pulses = 0;
    launch(10'h010, 10'd1, 10'h100, 10'd2, 1'b0);
    for (int t = 0; t <= TERM + 2; t++) begin
      if (t > 0) @(negedge clk);
      e = model(t, 10'h010, 10'd1, 10'h100, 10'd2);
      inp_cycles  += int'(matmul_op_in_progress);
      done_pulses += int'(done);
      checks++;
      if ((obs & care(t)) !== (e & care(t))) begin
        errors++;
        $display("FAIL nominal t=%0d got %s expected %s", t, fmt(obs), fmt(e));
      end
    end
    checks++;
    if (inp_cycles !== 25) begin
      errors++;
      $display("FAIL nominal_inp_len got %0d expected 25", inp_cycles);
    end
    checks++;
    if (done_pulses !== 1) begin
      errors++;
      $display("FAIL nominal_done_count got %0d expected 1", done_pulses);
    end
  endtask

  task automatic test_wrap;
    obs_t e;
    launch(10'h3FE, 10'd1, 10'h3F0, 10'h005, 1'b0);
    for (int t = 0; t <= TERM + 2; t++) begin
      if (t > 0) @(negedge clk);
      e = model(t, 10'h3FE, 10'd1, 10'h3F0, 10'h005);
      checks++;
      if ((obs & care(t)) !== (e & care(t))) begin
        errors++;
        $display("FAIL wrap t=%0d got %s expected %s", t, fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_start_busy;
    obs_t e;
    launch(10'h040, 10'd4, 10'h200, 10'd8, 1'b0);
    for (int t = 0; t <= TERM + 2; t++) begin
      if (t > 0) @(negedge clk);
      e = model(t, 10'h040, 10'd4, 10'h200, 10'd8);
      checks++;
      if ((obs & care(t)) !== (e & care(t))) begin
        errors++;
        $display("FAIL start_busy t=%0d got %s expected %s", t, fmt(obs), fmt(e));
      end
      start = (t == 5) || (t == TERM + 1) || (t == TERM + 2);
    end
    for (int t = 0; t <= TERM + 2; t++) begin
      @(negedge clk);
      e = model(t, 10'h040, 10'd4, 10'h200, 10'd8);
      checks++;
      if ((obs & care(t)) !== (e & care(t))) begin
        errors++;
        $display("FAIL start_after_done t=%0d got %s expected %s", t, fmt(obs), fmt(e));
      end
      start = 1'b0;
    end
  endtask

  task automatic test_abort(input int at);
    obs_t e;
    launch(10'h123, 10'd3, 10'h321, 10'd5, 1'b0);
    for (int t = 0; t <= at; t++) begin
      if (t > 0) @(negedge clk);
      e = model(t, 10'h123, 10'd3, 10'h321, 10'd5);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort_pre at=%0d t=%0d got %s expected %s", at, t, fmt(obs), fmt(e));
      end
    end
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      abort = 1'b0;
      e = '0;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort_post at=%0d i=%0d got %s expected %s", at, i, fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_reset_midop;
    obs_t e;
    launch(10'h0A0, 10'd2, 10'h0B0, 10'd3, 1'b0);
    for (int t = 0; t <= 3; t++) begin
      if (t > 0) @(negedge clk);
      e = model(t, 10'h0A0, 10'd2, 10'h0B0, 10'd3);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL midreset_pre t=%0d got %s expected %s", t, fmt(obs), fmt(e));
      end
    end
    #2 resetn = 1'b0;
    #1;
    e = '0;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL midreset_async got %s expected %s", fmt(obs), fmt(e));
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL midreset_idle i=%0d got %s expected %s", i, fmt(obs), fmt(e));
      end
    end
    launch(10'h0C0, 10'd1, 10'h0D0, 10'd1, 1'b0);
    for (int t = 0; t <= TERM + 2; t++) begin
      if (t > 0) @(negedge clk);
      e = model(t, 10'h0C0, 10'd1, 10'h0D0, 10'd1);
      checks++;
      if ((obs & care(t)) !== (e & care(t))) begin
        errors++;
        $display("FAIL after_reset t=%0d got %s expected %s", t, fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_base_change;
    obs_t e;
    launch(10'h020, 10'd3, 10'h080, 10'd6, 1'b0);
    for (int t = 0; t <= TERM + 2; t++) begin
      if (t > 0) @(negedge clk);
      e = model(t, 10'h020, 10'd3, 10'h080, 10'd6);
      checks++;
      if ((obs & care(t)) !== (e & care(t))) begin
        errors++;
        $display("FAIL base_change t=%0d got %s expected %s", t, fmt(obs), fmt(e));
      end
      if (t == 2) begin
        address_mat_a    = 10'h155;
        address_stride_a = 10'd7;
        address_mat_b    = 10'h2AA;
        address_stride_b = 10'd9;
      end
    end
  endtask

  task automatic test_random;
    obs_t          e;
    logic [AW-1:0] ba, sa, bb, sb;
    int            st, chg;
    for (int op = 0; op < 8; op++) begin
      ba  = AW'($urandom_range(1023, 0));
      sa  = AW'($urandom_range(1023, 0));
      bb  = AW'($urandom_range(1023, 0));
      sb  = AW'($urandom_range(1023, 0));
      st  = int'($urandom_range(TERM, 1));
      chg = int'($urandom_range(TERM, 1));
      launch(ba, sa, bb, sb, 1'(op % 2));
      for (int t = 0; t <= TERM + 2; t++) begin
        if (t > 0) @(negedge clk);
        e = model(t, ba, sa, bb, sb);
        checks++;
        if ((obs & care(t)) !== (e & care(t))) begin
          errors++;
          $display("FAIL random op=%0d t=%0d got %s expected %s", op, t, fmt(obs), fmt(e));
        end
        start = (t == st);
        abort = (t == TERM + 1);
        if (t == chg) begin
          address_mat_a    = AW'($urandom_range(1023, 0));
          address_stride_a = AW'($urandom_range(1023, 0));
          address_mat_b    = AW'($urandom_range(1023, 0));
          address_stride_b = AW'($urandom_range(1023, 0));
        end
      end
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_wrap();
    test_start_busy();
    test_abort(10);
    test_abort(TERM);
    test_reset_midop();
    test_base_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_fetch_ctrl.md
MATMUL_FETCH_CTRL -- requirements
Module: matmul_fetch_ctrl

Interface
REQ-001 SHALL have parameter MAT_MUL_SIZE, default 8, meaning systolic array dimension and operand vectors fetched per matmul.
REQ-002 SHALL have parameter AWIDTH, default 10, meaning BRAM address width.
REQ-003 SHALL have parameter MEM_ACCESS_LATENCY, default 1, meaning BRAM read latency in cycles.
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-005 SHALL have ports: resetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: start  in  1  request to begin one matmul, sampled in IDLE only.
REQ-007 SHALL have ports: abort  in  1  synchronous cancel of an operation in progress.
REQ-008 SHALL have ports: address_mat_a / address_mat_b  in  AWIDTH  base addresses of A and B operand vectors.
REQ-009 SHALL have ports: address_stride_a / address_stride_b  in  AWIDTH  per-vector address increment for A and B.
REQ-010 SHALL have ports: a_addr / b_addr  out  AWIDTH  BRAM read addresses.
REQ-011 SHALL have ports: a_en / b_en  out  1  BRAM read enables.
REQ-012 SHALL have ports: matmul_op_in_progress  out  1  high for the whole FETCH state; feeds systolic data setup.
REQ-013 SHALL have ports: clk_cnt  out  8  cycle count within the operation; feeds systolic data setup.
REQ-014 SHALL have ports: done  out  1  single-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, FETCH, DONE; TERM = 3*MAT_MUL_SIZE + MEM_ACCESS_LATENCY - 1 (24 at defaults).
REQ-016 SHALL, in IDLE with start=1, move to FETCH on the next edge; latch bases and strides; set clk_cnt=0, matmul_op_in_progress=1, a_addr=address_mat_a, b_addr=address_mat_b, a_en=b_en=1.
REQ-017 SHALL, in FETCH, increment clk_cnt by 1 per cycle; at clk_cnt=k (k < MAT_MUL_SIZE) drive a_addr=base_a+k*stride_a and b_addr=base_b+k*stride_b, with a_en=b_en=1.
REQ-018 SHALL, in FETCH with clk_cnt >= MAT_MUL_SIZE, drive a_en=b_en=0 and hold a_addr/b_addr at their last issued values.
REQ-019 SHALL compute addresses with incremental adds modulo 2^AWIDTH (wrap silently, no flag).
REQ-020 SHALL ignore changes to base/stride inputs after acceptance until the next accepted start.
REQ-021 SHALL, in FETCH with clk_cnt == TERM and abort=0, go to DONE: matmul_op_in_progress=0, done=1, clk_cnt=0.
REQ-022 SHALL stay in DONE exactly one cycle, then return to IDLE with done=0.
REQ-023 SHALL ignore start while in FETCH or DONE (no queueing).
REQ-024 SHALL, on abort=1 in FETCH (including at clk_cnt == TERM), return to IDLE on the next edge with all outputs zero and no done pulse; abort has priority over termination.
REQ-025 SHALL ignore abort in IDLE and DONE; in IDLE, start and abort together accept start.
REQ-026 SHALL drive all outputs to 0 in IDLE.
REQ-027 SHALL make every output a register; no combinational input-to-output path.

Reset
REQ-028 SHALL, while resetn=0, immediately (asynchronously) force state=IDLE and all outputs to 0, including mid-FETCH.
REQ-029 SHALL discard latched bases/strides on reset; the first start after resetn rises is accepted normally.

Verification
REQ-030 Nominal: base_a=0x010, stride_a=1, base_b=0x100, stride_b=2, start pulse -> a_addr 0x010..0x017, b_addr 0x100,0x102..0x10E over clk_cnt 0..7, en low from clk_cnt=8, done pulse the cycle after clk_cnt=24, in_progress high 25 cycles.
REQ-031 Wrap: base_a=0x3FE, stride_a=1 -> a_addr 0x3FE,0x3FF,0x000..0x005.
REQ-032 Start while busy: second start at clk_cnt=5 -> ignored, exactly one done; start at the cycle after done (IDLE) -> accepted.
REQ-033 Abort at clk_cnt=10 -> next cycle all outputs 0, no done; abort coincident with clk_cnt=24 -> no done.
REQ-034 Reset mid-op: resetn low at clk_cnt=3 between edges -> outputs 0 without waiting for an edge; after release, idle until start.
REQ-035 Base change: address_mat_a changed at clk_cnt=2 -> a_addr sequence unaffected.
